config_loader: RTL and testbench

//  Configuration initiator for the tile array: it drives the shared config_addr/config_data bus that every PE tile decodes.
//  - Accepts a byte-wide bitstream over a valid/ready handshake.
//  - Assembles each 8-byte record into a {addr, data} pair.
//  - Issues each pair as a timed write on the config bus, then parks the bus at an address no tile decodes.
//  - Sits at the top level, between the external bitstream source and the tile grid.

---
 rtl/config_pkg.sv | 27 ++
 rtl/config_byte_assembler.sv | 46 ++++
 rtl/config_loader.sv | 153 +++++++++++++++
 tb/tb_config_loader.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/config_pkg.sv
// Shared definitions for the configuration loader and the tile array:
// tile block-type codes, default bus addresses and the loader state encoding.
package config_pkg;

  // Block types decoded from config_addr[31:16]; type 0 matches no tile.
  localparam logic [15:0] CONFIG_SB  = 16'd7;
  localparam logic [15:0] CONFIG_CB0 = 16'd6;
  localparam logic [15:0] CONFIG_CB1 = 16'd5;
  localparam logic [15:0] CONFIG_CLB = 16'd4;

  // Record address that terminates a bitstream, and the parked bus address.
  localparam logic [31:0] END_MARKER_DEFAULT = 32'hFFFF_FFFF;
  localparam logic [31:0] IDLE_ADDR_DEFAULT  = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DONE  = 2'd3
  } loader_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/config_byte_assembler.sv
// Collects an MSB-first byte stream into 8-byte {addr, data} records.
// The first seven bytes are held in a shift register; the record is
// presented combinationally together with the eighth byte so the loader
// can register it on the same edge that accepts that byte.
module config_byte_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        record_valid_o,
  output logic [31:0] record_addr_o,
  output logic [31:0] record_data_o
);

  logic [55:0] shift_q, shift_d;
  logic [2:0]  byte_cnt_q, byte_cnt_d;

  // Shift in accepted bytes; the 3-bit counter wraps from 7 back to 0.
  always_comb begin
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    if (clear_i) begin
      byte_cnt_d = 3'd0;
    end else if (byte_valid_i) begin
      shift_d    = {shift_q[47:0], byte_data_i};
      byte_cnt_d = byte_cnt_q + 3'd1;
    end
  end

  // Register the partial record; reset discards whatever was collected.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q    <= '0;
      byte_cnt_q <= 3'd0;
    end else begin
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  assign record_valid_o = byte_valid_i && !clear_i && (byte_cnt_q == 3'd7);
  assign record_addr_o  = shift_q[55:24];
  assign record_data_o  = {shift_q[23:0], byte_data_i};

endmodule

// File: rtl/config_loader.sv
// Configuration initiator for the tile array. Accepts a byte-wide bitstream,
// assembles 8-byte records and issues each one as a timed write on the
// shared config bus, parking the bus at IDLE_ADDR between writes.
// Optional feature macro: CONFIG_LOADER_CHECKSUM_EN enables a running
// addr+data sum that is compared against the terminator record's data.
module config_loader
  import config_pkg::*;
#(
  parameter int          HOLD_CYCLES = 1,
  parameter logic [31:0] END_MARKER  = END_MARKER_DEFAULT,
  parameter logic [31:0] IDLE_ADDR   = IDLE_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [31:0] config_addr,
  output logic [31:0] config_data,
  output logic        busy,
  output logic        done,
  output logic [15:0] words_written,
  output logic        error
);

  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

  loader_state_e state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic [15:0]   hold_q, hold_d;
  logic [15:0]   words_q, words_d;

  logic          start_accept;
  logic          byte_fire;
  logic          rec_valid;
  logic [31:0]   rec_addr;
  logic [31:0]   rec_data;

`ifdef CONFIG_LOADER_CHECKSUM_EN
  logic [31:0]   sum_q, sum_d;
  logic          error_q, error_d;
`endif

  assign start_accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign byte_fire    = in_valid && (state_q == ST_LOAD);

  config_byte_assembler u_assembler (
    .clk            (clk),
    .reset          (reset),
    .clear_i        (start_accept),
    .byte_valid_i   (byte_fire),
    .byte_data_i    (in_data),
    .record_valid_o (rec_valid),
    .record_addr_o  (rec_addr),
    .record_data_o  (rec_data)
  );

  // Next-state logic: load records, hold each write for HOLD_CYCLES, park the bus.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    hold_d  = hold_q;
    words_d = words_q;
`ifdef CONFIG_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
    error_d = error_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_LOAD;
          words_d = 16'd0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
          sum_d   = 32'd0;
          error_d = 1'b0;
`endif
        end
      end
      ST_LOAD: begin
        if (rec_valid) begin
          if (rec_addr == END_MARKER) begin
            state_d = ST_DONE;
`ifdef CONFIG_LOADER_CHECKSUM_EN
            error_d = (rec_data != sum_q);
`endif
          end else begin
            state_d = ST_ISSUE;
            addr_d  = rec_addr;
            data_d  = rec_data;
            hold_d  = 16'd0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
            sum_d   = sum_q + rec_addr + rec_data;
`endif
          end
        end
      end
      ST_ISSUE: begin
        if (hold_q == HOLD_LAST) begin
          state_d = ST_LOAD;
          addr_d  = IDLE_ADDR;
          data_d  = 32'd0;
          words_d = sat_inc16(words_q);
        end else begin
          hold_d  = hold_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and bus registers; reset drops any partial record and parks the bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= IDLE_ADDR;
      data_q  <= 32'd0;
      hold_q  <= 16'd0;
      words_q <= 16'd0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
      sum_q   <= 32'd0;
      error_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      hold_q  <= hold_d;
      words_q <= words_d;
`ifdef CONFIG_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
      error_q <= error_d;
`endif
    end
  end

  assign in_ready      = (state_q == ST_LOAD);
  assign busy          = (state_q == ST_LOAD) || (state_q == ST_ISSUE);
  assign done          = (state_q == ST_DONE);
  assign config_addr   = addr_q;
  assign config_data   = data_q;
  assign words_written = words_q;
`ifdef CONFIG_LOADER_CHECKSUM_EN
  assign error         = error_q;
`else
  assign error         = 1'b0;
`endif

endmodule

// File: tb/tb_config_loader.sv
// Directed testbench for config_loader. Two instances share clock and reset:
// dutA uses the default single-cycle hold, dutB holds each write for 3 cycles.
// A selector routes valid/start to one instance at a time.
module tb_config_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        sel;

  logic        startA, validA, readyA, busyA, doneA, errorA;
  logic [31:0] addrA, dataA;
  logic [15:0] wordsA;
  logic        startB, validB, readyB, busyB, doneB, errorB;
  logic [31:0] addrB, dataB;
  logic [15:0] wordsB;
  logic        rdy;

  int errors = 0;
  int checks = 0;

  logic [31:0] logAddr[$];
  logic [31:0] logData[$];

  logic expErrBad;

  assign startA = start & ~sel;
  assign validA = in_valid & ~sel;
  assign startB = start & sel;
  assign validB = in_valid & sel;
  assign rdy    = sel ? readyB : readyA;

  config_loader #(.HOLD_CYCLES(1)) dutA (
    .clk(clk), .reset(reset), .start(startA), .in_valid(validA), .in_data(in_data),
    .in_ready(readyA), .config_addr(addrA), .config_data(dataA), .busy(busyA),
    .done(doneA), .words_written(wordsA), .error(errorA)
  );

  config_loader #(.HOLD_CYCLES(3)) dutB (
    .clk(clk), .reset(reset), .start(startB), .in_valid(validB), .in_data(in_data),
    .in_ready(readyB), .config_addr(addrB), .config_data(dataB), .busy(busyB),
    .done(doneB), .words_written(wordsB), .error(errorB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every cycle in which dutA's bus is away from its parked value.
  always @(negedge clk) begin
    if (!reset && (addrA !== 32'h0 || dataA !== 32'h0)) begin
      logAddr.push_back(addrA);
      logData.push_back(dataA);
    end
  end

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Present one byte and wait (bounded) until it is accepted.
  task automatic sendByte(input logic [7:0] b);
    int n;
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (rdy !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (rdy !== 1'b1) begin
      errors++;
      checks++;
      $display("[TB] FAIL sendByte timeout: in_ready=%b required=1", rdy);
    end
    @(negedge clk);
  endtask

  // Send a full record MSB-first; gap inserts an idle valid cycle before each byte.
  task automatic sendRecord(input logic [31:0] a, input logic [31:0] d, input bit gap);
    logic [63:0] rec;
    rec = {a, d};
    for (int i = 0; i < 8; i++) begin
      if (gap) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      sendByte(rec[63 - 8*i -: 8]);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    pulseReset();
    checks++; if (addrA !== 32'h0)  begin errors++; $display("[TB] FAIL reset addr: got %h want 00000000", addrA); end
    checks++; if (dataA !== 32'h0)  begin errors++; $display("[TB] FAIL reset data: got %h want 00000000", dataA); end
    checks++; if (readyA !== 1'b0)  begin errors++; $display("[TB] FAIL reset in_ready: got %b want 0", readyA); end
    checks++; if (busyA !== 1'b0 || doneA !== 1'b0) begin errors++; $display("[TB] FAIL reset busy/done: got %b/%b want 0/0", busyA, doneA); end
    checks++; if (wordsA !== 16'd0 || errorA !== 1'b0) begin errors++; $display("[TB] FAIL reset words/error: got %0d/%b want 0/0", wordsA, errorA); end
  endtask

  task automatic test_single_write();
    logAddr.delete(); logData.delete();
    pulseStart();
    checks++; if (readyA !== 1'b1 || busyA !== 1'b1) begin errors++; $display("[TB] FAIL load ready/busy: got %b/%b want 1/1", readyA, busyA); end
    sendRecord(32'h0007_0003, 32'h0000_0005, 1'b0);
    checks++; if (addrA !== 32'h0007_0003 || dataA !== 32'h5) begin errors++; $display("[TB] FAIL write1 bus: got %h/%h want 00070003/00000005", addrA, dataA); end
    checks++; if (readyA !== 1'b0) begin errors++; $display("[TB] FAIL write1 in_ready in issue: got %b want 0", readyA); end
    @(negedge clk);
    checks++; if (addrA !== 32'h0 || dataA !== 32'h0) begin errors++; $display("[TB] FAIL write1 park: got %h/%h want 00000000/00000000", addrA, dataA); end
    checks++; if (wordsA !== 16'd1 || readyA !== 1'b1) begin errors++; $display("[TB] FAIL write1 words/ready: got %0d/%b want 1/1", wordsA, readyA); end
    @(negedge clk);
    checks++; if (logAddr.size() != 1) begin errors++; $display("[TB] FAIL write1 bus cycles: got %0d want 1", logAddr.size()); end
  endtask

  task automatic test_terminator();
    logic [31:0] ea[3];
    logic [31:0] ed[3];
    ea[0] = 32'h0004_0001; ed[0] = 32'h0000_0011;
    ea[1] = 32'h0005_0002; ed[1] = 32'h0000_0022;
    ea[2] = 32'h0007_0003; ed[2] = 32'h0000_0033;
    pulseReset();
    logAddr.delete(); logData.delete();
    pulseStart();
    for (int i = 0; i < 3; i++) sendRecord(ea[i], ed[i], 1'b0);
    sendRecord(32'hFFFF_FFFF, 32'h0, 1'b0);
    checks++; if (doneA !== 1'b1 || busyA !== 1'b0) begin errors++; $display("[TB] FAIL term done/busy: got %b/%b want 1/0", doneA, busyA); end
    checks++; if (wordsA !== 16'd3) begin errors++; $display("[TB] FAIL term words: got %0d want 3", wordsA); end
    in_valid = 1'b1;
    in_data  = 8'hAB;
    repeat (3) @(negedge clk);
    checks++; if (readyA !== 1'b0 || doneA !== 1'b1) begin errors++; $display("[TB] FAIL term hold ready/done: got %b/%b want 0/1", readyA, doneA); end
    in_valid = 1'b0;
    checks++; if (logAddr.size() != 3) begin errors++; $display("[TB] FAIL term write count: got %0d want 3", logAddr.size()); end
    for (int i = 0; i < 3 && i < logAddr.size(); i++) begin
      checks++;
      if (logAddr[i] !== ea[i] || logData[i] !== ed[i]) begin
        errors++; $display("[TB] FAIL term write%0d: got %h/%h want %h/%h", i, logAddr[i], logData[i], ea[i], ed[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logAddr.delete(); logData.delete();
    pulseStart();
    sendRecord(32'h0006_1234, 32'hDEAD_BEEF, 1'b1);
    sendByte(8'h00);
    sendByte(8'h04);
    in_valid = 1'b0;
    pulseStart();
    sendByte(8'h56);
    sendByte(8'h78);
    sendByte(8'hCA);
    sendByte(8'hFE);
    in_valid = 1'b0;
    @(negedge clk);
    sendByte(8'hF0);
    in_valid = 1'b0;
    @(negedge clk);
    sendByte(8'h0D);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (wordsA !== 16'd2) begin errors++; $display("[TB] FAIL b2b words: got %0d want 2", wordsA); end
    checks++; if (logAddr.size() != 2) begin errors++; $display("[TB] FAIL b2b write count: got %0d want 2", logAddr.size()); end
    if (logAddr.size() >= 2) begin
      checks++; if (logAddr[0] !== 32'h0006_1234 || logData[0] !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL b2b write0: got %h/%h want 00061234/deadbeef", logAddr[0], logData[0]); end
      checks++; if (logAddr[1] !== 32'h0004_5678 || logData[1] !== 32'hCAFE_F00D) begin errors++; $display("[TB] FAIL b2b write1: got %h/%h want 00045678/cafef00d", logAddr[1], logData[1]); end
    end
  endtask

  task automatic test_hold3();
    sel = 1'b1;
    pulseStart();
    sendRecord(32'h0006_0004, 32'hA5A5_0001, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (addrB !== 32'h0006_0004 || dataB !== 32'hA5A5_0001 || readyB !== 1'b0) begin
        errors++; $display("[TB] FAIL hold3 cycle%0d: got %h/%h ready=%b want 00060004/a5a50001 ready=0", k, addrB, dataB, readyB);
      end
      @(negedge clk);
    end
    checks++; if (addrB !== 32'h0 || readyB !== 1'b1 || wordsB !== 16'd1) begin errors++; $display("[TB] FAIL hold3 end: got %h ready=%b words=%0d want 00000000 ready=1 words=1", addrB, readyB, wordsB); end
    sel = 1'b0;
  endtask

  task automatic test_reset_mid();
    logAddr.delete(); logData.delete();
    sendByte(8'h00); sendByte(8'h05); sendByte(8'h00); sendByte(8'h01); sendByte(8'h99);
    in_valid = 1'b0;
    pulseReset();
    checks++; if (addrA !== 32'h0 || wordsA !== 16'd0 || readyA !== 1'b0 || busyA !== 1'b0) begin errors++; $display("[TB] FAIL midrec reset: got %h words=%0d ready=%b busy=%b want 00000000 0 0 0", addrA, wordsA, readyA, busyA); end
    pulseStart();
    sendRecord(32'h0006_0011, 32'h0000_0077, 1'b0);
    @(negedge clk);
    checks++; if (logAddr.size() != 1) begin errors++; $display("[TB] FAIL midrec write count: got %0d want 1", logAddr.size()); end
    else begin
      checks++; if (logAddr[0] !== 32'h0006_0011 || logData[0] !== 32'h77) begin errors++; $display("[TB] FAIL midrec write: got %h/%h want 00060011/00000077", logAddr[0], logData[0]); end
    end
    sendRecord(32'h0005_0022, 32'h0000_0088, 1'b0);
    checks++; if (addrA !== 32'h0005_0022) begin errors++; $display("[TB] FAIL issue addr before reset: got %h want 00050022", addrA); end
    pulseReset();
    checks++; if (addrA !== 32'h0 || dataA !== 32'h0 || wordsA !== 16'd0) begin errors++; $display("[TB] FAIL midissue reset: got %h/%h words=%0d want 00000000/00000000 0", addrA, dataA, wordsA); end
  endtask

  task automatic test_checksum();
`ifdef CONFIG_LOADER_CHECKSUM_EN
    expErrBad = 1'b1;
`else
    expErrBad = 1'b0;
`endif
    pulseReset();
    pulseStart();
    sendRecord(32'h0005_0001, 32'h2, 1'b0);
    sendRecord(32'h0004_0002, 32'h3, 1'b0);
    sendRecord(32'hFFFF_FFFF, 32'h0009_0008, 1'b0);
    checks++; if (doneA !== 1'b1 || errorA !== 1'b0) begin errors++; $display("[TB] FAIL csum good: got done=%b error=%b want 1/0", doneA, errorA); end
    pulseStart();
    sendRecord(32'h0005_0001, 32'h2, 1'b0);
    sendRecord(32'h0004_0002, 32'h3, 1'b0);
    sendRecord(32'hFFFF_FFFF, 32'h0009_0009, 1'b0);
    checks++; if (doneA !== 1'b1 || errorA !== expErrBad) begin errors++; $display("[TB] FAIL csum bad: got done=%b error=%b want 1/%b", doneA, errorA, expErrBad); end
    @(negedge clk);
    checks++; if (errorA !== expErrBad) begin errors++; $display("[TB] FAIL csum sticky: got %b want %b", errorA, expErrBad); end
    pulseStart();
    checks++; if (errorA !== 1'b0 || doneA !== 1'b0 || wordsA !== 16'd0) begin errors++; $display("[TB] FAIL csum clear: got error=%b done=%b words=%0d want 0/0/0", errorA, doneA, wordsA); end
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    sel      = 1'b0;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    test_single_write();
    test_terminator();
    test_back_to_back();
    test_hold3();
    test_reset_mid();
    test_checksum();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
